// File: rtl/mod3_2_unfold.sv
// Overlap-add unfold decoder: subtracts the stored tail of the previous packet from the head samples.
// Optional MOD3_UNFOLD_ERR_CLEAR_EN: a packet length error also clears the stored tail.
module mod3_2_unfold #(
   parameter int packet_length = 8,
   parameter int data_width    = 8,
   parameter int config_k      = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [data_width-1:0] input_tdata,
   input  logic                  input_tvalid,
   output logic                  input_tready,
   input  logic                  input_tlast,
   output logic [data_width-1:0] output_tdata,
   output logic                  output_tvalid,
   input  logic                  output_tready,
   output logic                  output_tlast,
   output logic                  pkt_err
);

   localparam int L  = packet_length;
   localparam int K  = config_k;
   localparam int W  = data_width;
   localparam int T  = L - K;
   localparam int CW = (L > 2) ? $clog2(L) : 1;

   generate
      if (K < 1 || K > L - 1) begin : g_bad_k
         $error("config_k must satisfy 1 <= config_k <= packet_length-1");
      end
   endgenerate

   logic [W-1:0]  data_q, data_d;
   logic          valid_q, valid_d;
   logic          last_q, last_d;
   logic          err_q, err_d;
   logic [CW-1:0] n_q, n_d;
   logic [W-1:0]  tail_q [K];
   logic [W-1:0]  tail_d [K];

   logic          acc;
   logic          head;
   logic          at_end;
   logic [W-1:0]  rd;
   logic [W-1:0]  res;

   assign input_tready  = !valid_q || output_tready;
   assign acc           = input_tvalid && input_tready;
   assign output_tdata  = data_q;
   assign output_tvalid = valid_q;
   assign output_tlast  = last_q;
   assign pkt_err       = err_q;

   always_comb begin
      rd = '0;
      for (int i = 0; i < K; i++) begin
         if (n_q == CW'(i)) rd = tail_q[i];
      end
      head   = (n_q < CW'(K));
      at_end = (n_q == CW'(L - 1));
      res    = head ? (input_tdata - rd) : input_tdata;

      data_d  = data_q;
      last_d  = last_q;
      valid_d = valid_q;
      n_d     = n_q;
      err_d   = 1'b0;
      tail_d  = tail_q;

      if (acc) begin
         data_d  = res;
         last_d  = input_tlast || at_end;
         valid_d = 1'b1;
         err_d   = (input_tlast != at_end);
         n_d     = (input_tlast || at_end) ? '0 : n_q + CW'(1);
         // Tail stores recovered samples; the head read above saw old contents.
         for (int i = 0; i < K; i++) begin
            if (n_q == CW'(T + i)) tail_d[i] = res;
         end
`ifdef MOD3_UNFOLD_ERR_CLEAR_EN
         if (err_d) begin
            for (int i = 0; i < K; i++) tail_d[i] = '0;
         end
`endif
      end else if (output_tready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
         n_q     <= '0;
         for (int i = 0; i < K; i++) tail_q[i] <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         err_q   <= err_d;
         n_q     <= n_d;
         for (int i = 0; i < K; i++) tail_q[i] <= tail_d[i];
      end
   end

endmodule

// File: tb/tb_mod3_2_unfold.sv
// Directed bench for mod3_2_unfold (L=8, K=3, 8-bit samples).
// Expected values follow the encoder rule; honours MOD3_UNFOLD_ERR_CLEAR_EN.
module tb_mod3_2_unfold;

   logic       clk;
   logic       reset;
   logic [7:0] input_tdata;
   logic       input_tvalid;
   logic       input_tready;
   logic       input_tlast;
   logic [7:0] output_tdata;
   logic       output_tvalid;
   logic       output_tready;
   logic       output_tlast;
   logic       pkt_err;

   int n_chk;
   int n_fail;

   typedef struct {
      logic [7:0] y;
      logic       l;
      logic [7:0] x;
      logic       xl;
      logic       e;
   } vec_t;

   vec_t vq[$];

   mod3_2_unfold #(
      .packet_length(8),
      .data_width   (8),
      .config_k     (3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .input_tdata  (input_tdata),
      .input_tvalid (input_tvalid),
      .input_tready (input_tready),
      .input_tlast  (input_tlast),
      .output_tdata (output_tdata),
      .output_tvalid(output_tvalid),
      .output_tready(output_tready),
      .output_tlast (output_tlast),
      .pkt_err      (pkt_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  name, act, act, exp, exp);
      end
   endtask

   task automatic add(input int y, input bit l, input int x,
                      input bit xl, input bit e);
      vec_t v;
      v.y  = 8'(y);
      v.l  = l;
      v.x  = 8'(x);
      v.xl = xl;
      v.e  = e;
      vq.push_back(v);
   endtask

   task automatic beat(input string tag, input int y, input bit l,
                       input int x, input bit xl, input bit e);
      input_tdata  = 8'(y);
      input_tlast  = l;
      input_tvalid = 1'b1;
      @(posedge clk);
      #1;
      check({tag, ".data"}, int'(output_tdata), x);
      check({tag, ".last"}, int'(output_tlast), int'(xl));
      check({tag, ".valid"}, int'(output_tvalid), 1);
      check({tag, ".err"}, int'(pkt_err), int'(e));
   endtask

   initial begin
      n_chk         = 0;
      n_fail        = 0;
      reset         = 1'b1;
      input_tdata   = '0;
      input_tvalid  = 1'b0;
      input_tlast   = 1'b0;
      output_tready = 1'b1;

      // A: 1..8 on a zero history
      for (int i = 1; i <= 8; i++) add(i, i == 8, i, i == 8, 0);
      // B: head 16,18,20 minus tail 6,7,8
      add(16, 0, 10, 0, 0);
      add(18, 0, 11, 0, 0);
      add(20, 0, 12, 0, 0);
      for (int i = 13; i <= 17; i++) add(i, i == 17, i, i == 17, 0);
      // C: head minus 15,16,17 wraps; leaves tail 5,6,7
      add(1, 0, 8'hF2, 0, 0);
      add(2, 0, 8'hF2, 0, 0);
      add(3, 0, 8'hF2, 0, 0);
      add(4, 0, 4, 0, 0);
      add(5, 0, 5, 0, 0);
      add(5, 0, 5, 0, 0);
      add(6, 0, 6, 0, 0);
      add(7, 1, 7, 1, 0);
      // D: 0x02 - 0x05 = 0xFD; leaves tail 3,4,5
      add(2, 0, 8'hFD, 0, 0);
      add(6, 0, 0, 0, 0);
      add(7, 0, 0, 0, 0);
      for (int i = 1; i <= 5; i++) add(i, i == 5, i, i == 5, 0);
      // E: early tlast on beat 5
      add(10, 0, 7, 0, 0);
      add(11, 0, 7, 0, 0);
      add(12, 0, 7, 0, 0);
      add(13, 0, 13, 0, 0);
      add(14, 1, 14, 1, 1);
      // F: starts at n=0; head uses old tail or zero if cleared
`ifdef MOD3_UNFOLD_ERR_CLEAR_EN
      add(20, 0, 20, 0, 0);
      add(21, 0, 21, 0, 0);
      add(22, 0, 22, 0, 0);
`else
      add(20, 0, 17, 0, 0);
      add(21, 0, 17, 0, 0);
      add(22, 0, 17, 0, 0);
`endif
      for (int i = 23; i <= 27; i++) add(i, i == 27, i, i == 27, 0);
      // G: missing tlast on beat 8
      add(30, 0, 5, 0, 0);
      add(31, 0, 5, 0, 0);
      add(32, 0, 5, 0, 0);
      for (int i = 1; i <= 5; i++) add(i, 0, i, i == 5, i == 5);
      // H: head after missing-tlast packet
`ifdef MOD3_UNFOLD_ERR_CLEAR_EN
      add(10, 0, 10, 0, 0);
      add(10, 0, 10, 0, 0);
      add(10, 0, 10, 0, 0);
`else
      add(10, 0, 7, 0, 0);
      add(10, 0, 6, 0, 0);
      add(10, 0, 5, 0, 0);
`endif
      for (int i = 0; i < 5; i++) add(0, i == 4, 0, i == 4, 0);

      repeat (2) @(posedge clk);
      #1;
      check("rst.data", int'(output_tdata), 0);
      check("rst.valid", int'(output_tvalid), 0);
      check("rst.last", int'(output_tlast), 0);
      check("rst.err", int'(pkt_err), 0);
      check("rst.ready", int'(input_tready), 1);
      reset = 1'b0;

      foreach (vq[i]) begin
         beat($sformatf("vec%0d", i), vq[i].y, vq[i].l,
              vq[i].x, vq[i].xl, vq[i].e);
      end
      input_tvalid = 1'b0;
      @(posedge clk);
      #1;
      check("drain.valid", int'(output_tvalid), 0);
      check("drain.err", int'(pkt_err), 0);

      // Backpressure: tail is zero here, packet 1..8 passes unchanged
      beat("bp1", 1, 0, 1, 0, 0);
      output_tready = 1'b0;
      input_tdata   = 8'd2;
      input_tlast   = 1'b0;
      #1;
      check("bp.ready", int'(input_tready), 0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp.hold%0d.data", c), int'(output_tdata), 1);
         check($sformatf("bp.hold%0d.last", c), int'(output_tlast), 0);
         check($sformatf("bp.hold%0d.valid", c), int'(output_tvalid), 1);
         check($sformatf("bp.hold%0d.ready", c), int'(input_tready), 0);
      end
      output_tready = 1'b1;
      for (int i = 2; i <= 8; i++) begin
         beat($sformatf("bp%0d", i), i, i == 8, i, i == 8, 0);
      end

      // Reset on beat 4 discards the beat and all history (tail 6,7,8)
      beat("rm1", 50, 0, 44, 0, 0);
      beat("rm2", 51, 0, 44, 0, 0);
      beat("rm3", 52, 0, 44, 0, 0);
      input_tdata = 8'd53;
      reset       = 1'b1;
      @(posedge clk);
      #1;
      check("rm.data", int'(output_tdata), 0);
      check("rm.valid", int'(output_tvalid), 0);
      check("rm.last", int'(output_tlast), 0);
      check("rm.err", int'(pkt_err), 0);
      reset        = 1'b0;
      input_tvalid = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 1; i <= 8; i++) begin
         beat($sformatf("pr%0d", i), i, i == 8, i, i == 8, 0);
      end
      input_tvalid = 1'b0;
      @(posedge clk);
      #1;
      check("end.valid", int'(output_tvalid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mod3_2_unfold.md
Name: mod3_2_unfold

Overview:
- AXI-Stream decoder for the packet overlap-add folding stage (encoder side).
- Encoder rule, per packet p of packet_length samples: y_p[n] = x_p[n] + x_{p-1}[packet_length-config_k+n] for n < config_k; y_p[n] = x_p[n] otherwise.
- This block recovers x_p by subtracting the stored tail of the previously recovered packet from the first config_k samples.
- Sits directly downstream of the folding stage (or its channel), before sample consumers.

Parameters:
packet_length, 8, samples per packet (L); must be >= 2
data_width, 8, sample width in bits
config_k, 3, folded head/tail length (K); 1 <= K <= L-1, elaboration error otherwise

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
input_tdata  input  data_width  folded sample y
input_tvalid  input  1  input sample valid
input_tready  output  1  block can accept input this cycle
input_tlast  input  1  last sample of input packet
output_tdata  output  data_width  recovered sample x
output_tvalid  output  1  output sample valid
output_tready  input  1  downstream can accept
output_tlast  output  1  last sample of recovered packet
pkt_err  output  1  one-cycle pulse on packet length mismatch

Behaviour:
- Reset (reset=1 at a clk edge) forces: output_tdata=0, output_tvalid=0, output_tlast=0, pkt_err=0, sample counter n=0, all K tail entries=0.
- After reset, the first packet decodes as if preceded by an all-zero packet. Reset mid-packet discards the in-flight beat.
- Single output register stage. Latency is 1 cycle from an accepted input beat to output_tvalid.
- input_tready = !output_tvalid || output_tready. This is combinational, with no bubble at full throughput.
- Accept condition: input_tvalid && input_tready. Counter, tail and output register update only on accept.
- If output_tvalid=1 and output_tready=0: output_tdata and output_tlast are held stable and no input is accepted.
- output_tvalid is cleared when output_tready=1 and no new beat is accepted in the same cycle.
- Data path on accept at index n:
  - If n < K: out = input_tdata - tail[n], modulo 2^data_width (wrap, no saturation).
  - Otherwise: out = input_tdata.
- Tail update on accept: if n >= L-K, tail[n-(L-K)] <= out, i.e. the recovered value, not the folded value.
- When a beat both reads and writes the tail (n < K and n >= L-K, possible when 2K > L), the read uses the pre-update tail contents.
- Counter: n increments on each accept. It wraps to 0 after n = L-1, or on any accepted beat with input_tlast=1.
- output_tlast = input_tlast || (n == L-1), registered alongside the data.
- pkt_err pulses high for one cycle, the cycle after the accept, when either condition holds:
  - input_tlast=1 with n != L-1 (short packet); or
  - n == L-1 with input_tlast=0 (missing tlast).
- On a short packet, tail entries not yet written keep their prior values.
- Simultaneous output handshake and new accept: the register reloads with the new beat and output_tvalid stays 1.

Optional Feature:
- Macro: MOD3_UNFOLD_ERR_CLEAR_EN.
- Defined: on any beat raising pkt_err, all tail entries are cleared to 0 in the same update (overriding any write on that beat). The next packet decodes as the first after reset.
- Undefined: tail contents are retained across errors; pkt_err is status only.

Test Plan:
- L=8, K=3, reset, then packet y=1..8 with tlast on beat 8 -> output 1..8, output_tlast on 8th, pkt_err=0, tail=(6,7,8).
- Next packet y=16,18,20,13,14,15,16,17 -> output 10,11,12,13,14,15,16,17.
- Wrap: with tail[0]=0x05, head beat y=0x02 -> output 0xFD.
- Backpressure: output_tready low 3 cycles mid-packet -> output_tdata/tlast stable, output_tvalid=1, input_tready=0, no beat lost or duplicated.
- Early tlast on beat 5 -> output_tlast on beat 5, pkt_err one-cycle pulse, next beat decoded as n=0.
  - Repeat with MOD3_UNFOLD_ERR_CLEAR_EN: the next head subtracts 0.
- Reset asserted on beat 4 of a packet -> all outputs 0 next cycle. A following packet y=1..8 -> output 1..8, proving tail and counter cleared.
